// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
`ifndef ADDER_SIZE
`define ADDER_SIZE 64
`endif

package wide_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} wa_state_e;

  localparam int WA_BEATS = 4;
endpackage

// File: rtl/brent_kung_adder.sv
// W-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
`ifndef ADDER_SIZE
`define ADDER_SIZE 64
`endif

module brent_kung_adder #(
  parameter int W = `ADDER_SIZE
) (
  input  logic [W-1:0] in_op1,
  input  logic [W-1:0] in_op2,
  input  logic         cin,
  output logic [W-1:0] out_res,
  output logic         cout
);
  localparam int L = $clog2(W);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W-1:0] w_gg;
  logic [W-1:0] w_pp;
  logic [W:0]   w_c;

  assign w_g = in_op1 & in_op2;
  assign w_p = in_op1 ^ in_op2;

  // Up-sweep builds power-of-two spans; down-sweep fills the remaining prefixes.
  always_comb begin
    w_gg = w_g;
    w_pp = w_p;
    for (int l = 0; l < L; l++) begin
      for (int i = (2 << l) - 1; i < W; i += (2 << l)) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-(1<<l)]);
        w_pp[i] = w_pp[i] & w_pp[i-(1<<l)];
      end
    end
    for (int l = L - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < W; i += (2 << l)) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-(1<<l)]);
        w_pp[i] = w_pp[i] & w_pp[i-(1<<l)];
      end
    end
  end

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 1; i <= W; i++) begin
      w_c[i] = w_gg[i-1] | (w_pp[i-1] & cin);
    end
  end

  assign out_res = w_p ^ w_c[W-1:0];
  assign cout    = w_c[W];
endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one W-bit adder reused LSB-first over BEATS
// chunks, carry chained through a register, results returned on valid/ready.
`ifndef ADDER_SIZE
`define ADDER_SIZE 64
`endif

module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int W     = `ADDER_SIZE,
  parameter int BEATS = WA_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*BEATS-1:0] in_op1,
  input  logic [W*BEATS-1:0] in_op2,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*BEATS-1:0] out_res,
  output logic               out_cout,
  output logic               out_ovf
);
  localparam int N  = W * BEATS;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  wa_state_e     r_state;
  wa_state_e     w_state_nxt;
  logic [BW-1:0] r_beat;
  logic          r_carry;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_res;
  logic          r_cout;
  logic          r_ovf;

  logic [W-1:0]  w_sum;
  logic          w_cout;
  logic          w_ovf;
  logic          w_last;
  logic [N-1:0]  w_acc_nxt;

  brent_kung_adder #(.W(W)) u_adder (
    .in_op1  (r_a[W-1:0]),
    .in_op2  (r_b[W-1:0]),
    .cin     (r_carry),
    .out_res (w_sum),
    .cout    (w_cout)
  );

  assign w_last    = (r_beat == LAST_BEAT);
  assign w_ovf     = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
  assign w_acc_nxt = {w_sum, r_acc[N-1:W]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // The visible result is only refreshed on the final beat, so it stays
  // stable through DONE and across handoff until the next op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_op1;
            r_b     <= in_sub ? ~in_op2 : in_op2;
            r_carry <= in_sub ? 1'b1 : in_cin;
            r_beat  <= '0;
          end
        end
        RUN: begin
          r_a     <= {{W{1'b0}}, r_a[N-1:W]};
          r_b     <= {{W{1'b0}}, r_b[N-1:W]};
          r_acc   <= w_acc_nxt;
          r_carry <= w_cout;
          if (w_last) begin
            r_res  <= w_acc_nxt;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_res   = r_res;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
endmodule
